// File: rtl/cdr_pkg.sv
// Shared types and helpers for the CDR phase-select controller.
//   state_t     : loop filter FSM states
//   VOTE_*      : signed 2-bit phase detector vote encodings
//   phase_wrap  : modulo step of a phase pointer (explicit compare, so any
//                 NPHASE >= 2 wraps correctly, not just powers of two)
package cdr_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_TRACK,
    S_SETTLE
  } state_t;

  localparam logic signed [1:0] VOTE_UP   = 2'sb01;
  localparam logic signed [1:0] VOTE_DN   = 2'sb11;
  localparam logic signed [1:0] VOTE_HOLD = 2'sb00;

  // dir=1 -> +1, dir=0 -> -1, modulo nphase.
  function automatic int phase_wrap(input int ptr, input logic dir, input int nphase);
    if (dir) return (ptr == nphase - 1) ? 0 : ptr + 1;
    else     return (ptr == 0) ? nphase - 1 : ptr - 1;
  endfunction

endpackage

// File: rtl/lock_detector.sv
// Lock indicator for the CDR loop.
//   clk, rst      : clock, async active-low reset
//   active        : loop running (enabled and out of IDLE); 0 clears everything
//   step/step_dir : step event and its direction, same cycle the pointer moves
//   locked        : set after LOCK_WIN step-free cycles; cleared by a
//                   same-direction step pair (trend) or by going inactive.
//                   Dither (alternating steps) restarts the quiet count only.
module lock_detector #(
  parameter int LOCK_WIN = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic active,
  input  logic step,
  input  logic step_dir,
  output logic locked
);

  localparam int QW = $clog2(LOCK_WIN + 1);

  logic [QW-1:0] quiet, quiet_next;
  logic          last_vld, last_dir;
  logic          trend;

  assign trend = step && last_vld && (step_dir == last_dir);

  always_comb begin
    quiet_next = quiet;
    if (!active || step)               quiet_next = '0;
    else if (quiet != QW'(LOCK_WIN))   quiet_next = quiet + 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      quiet    <= '0;
      last_vld <= 1'b0;
      last_dir <= 1'b0;
      locked   <= 1'b0;
    end else begin
      quiet <= quiet_next;
      if (!active) begin
        last_vld <= 1'b0;
        last_dir <= 1'b0;
        locked   <= 1'b0;
      end else begin
        if (step) begin
          last_vld <= 1'b1;
          last_dir <= step_dir;
        end
        // Sticky: only a trend (or going inactive) knocks lock down.
        if (trend)                               locked <= 1'b0;
        else if (quiet_next == QW'(LOCK_WIN))    locked <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/phase_select_ctrl.sv
// Bang-bang CDR loop filter and multiphase clock pointer.
//   clk, rst  : clock, async active-low reset
//   en        : loop enable; low returns to IDLE, pointer retained
//   up, down  : phase detector votes (registered before use)
//   phase_sel : selected phase index
//   step      : one-cycle pulse per pointer change
//   step_dir  : direction of last step (1 = +1), held
//   locked    : lock indicator from lock_detector
module phase_select_ctrl
  import cdr_pkg::*;
#(
  parameter int NPHASE   = 8,
  parameter int THRESH   = 4,
  parameter int SETTLE   = 3,
  parameter int LOCK_WIN = 64,
  parameter int PSEL_W   = $clog2(NPHASE),
  parameter int ACC_W    = $clog2(THRESH) + 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              up,
  input  logic              down,
  output logic [PSEL_W-1:0] phase_sel,
  output logic              step,
  output logic              step_dir,
  output logic              locked
);

  localparam int CNT_W = $clog2(SETTLE + 1);
  localparam logic signed [ACC_W-1:0] POS_T = ACC_W'(THRESH);
  localparam logic signed [ACC_W-1:0] NEG_T = ACC_W'(-THRESH);

  state_t                   state;
  logic                     up_q, down_q;
  logic signed [1:0]        vote;
  logic signed [ACC_W-1:0]  acc, acc_next, vote_ext;
  logic [CNT_W-1:0]         settle_cnt;
  logic                     hit_up, hit_dn, active;

  always_comb begin
    vote = VOTE_HOLD;
    if (up_q && !down_q)      vote = VOTE_UP;
    else if (down_q && !up_q) vote = VOTE_DN;
  end

  assign vote_ext = {{(ACC_W-2){vote[1]}}, vote};
  assign acc_next = acc + vote_ext;
  assign hit_up   = en && (state == S_TRACK) && (acc_next == POS_T);
  assign hit_dn   = en && (state == S_TRACK) && (acc_next == NEG_T);
  assign active   = en && (state != S_IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_IDLE;
      up_q       <= 1'b0;
      down_q     <= 1'b0;
      acc        <= '0;
      settle_cnt <= '0;
      phase_sel  <= '0;
      step       <= 1'b0;
      step_dir   <= 1'b0;
    end else begin
      up_q   <= up;
      down_q <= down;
      step   <= 1'b0;
      if (!en) begin
        state      <= S_IDLE;
        acc        <= '0;
        settle_cnt <= '0;
      end else begin
        case (state)
          S_IDLE: begin
            acc   <= '0;
            state <= S_TRACK;
          end
          S_TRACK: begin
            if (hit_up || hit_dn) begin
              phase_sel  <= PSEL_W'(phase_wrap(int'(phase_sel), hit_up, NPHASE));
              step       <= 1'b1;
              step_dir   <= hit_up;
              acc        <= '0;
              settle_cnt <= CNT_W'(SETTLE);
              state      <= S_SETTLE;
            end else begin
              acc <= acc_next;
            end
          end
          S_SETTLE: begin
            // Leaving on the cycle the count hits 0 gives exactly SETTLE blanked cycles.
            acc <= '0;
            if (settle_cnt <= CNT_W'(1)) begin
              settle_cnt <= '0;
              state      <= S_TRACK;
            end else begin
              settle_cnt <= settle_cnt - 1'b1;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  lock_detector #(.LOCK_WIN(LOCK_WIN)) u_lock (
    .clk      (clk),
    .rst      (rst),
    .active   (active),
    .step     (hit_up || hit_dn),
    .step_dir (hit_up),
    .locked   (locked)
  );

endmodule
